// File: rtl/smu_pkg.sv
// Shared types for the smu trigger controller: channel FSM state encoding.
package smu_pkg;

    typedef enum logic [1:0] {
        TC_IDLE   = 2'd0,
        TC_ACTIVE = 2'd1,
        TC_STICKY = 2'd2
    } tc_state_e;

endpackage

// File: rtl/smu_trigger_ctrl_chan.sv
// One patch-control channel: IDLE/ACTIVE/STICKY FSM with a reloadable hold counter.
module smu_trigger_ctrl_chan
    import smu_pkg::*;
#(
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hit,
    input  logic              clr,
    input  logic [HOLD_W-1:0] hold,
    input  logic              sticky,
    output logic              ctrl,
    output logic              start
);

    tc_state_e         state_q, state_d;
    logic [HOLD_W-1:0] hcnt_q,  hcnt_d;
    logic              ctrl_q,  ctrl_d;

    // Channel state, hold counter and registered control output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TC_IDLE;
            hcnt_q  <= '0;
            ctrl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Next-state logic; a clear always wins over a same-cycle hit, which is dropped
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        start   = 1'b0;
        case (state_q)
            TC_IDLE: begin
                if (clr) begin
                    state_d = TC_IDLE;
                end else if (hit) begin
                    start = 1'b1;
                    if (sticky) begin
                        state_d = TC_STICKY;
                    end else begin
                        state_d = TC_ACTIVE;
                        hcnt_d  = hold;
                    end
                end else begin
                    state_d = TC_IDLE;
                end
            end
            TC_ACTIVE: begin
                if (clr) begin
                    state_d = TC_IDLE;
                end else if (hit) begin
                    hcnt_d = hold;
                end else if (hcnt_q == {HOLD_W{1'b0}}) begin
                    state_d = TC_IDLE;
                end else begin
                    hcnt_d = hcnt_q - {{(HOLD_W-1){1'b0}}, 1'b1};
                end
            end
            TC_STICKY: begin
                if (clr) begin
                    state_d = TC_IDLE;
                end else begin
                    state_d = TC_STICKY;
                end
            end
            default: begin
                state_d = TC_IDLE;
                hcnt_d  = '0;
            end
        endcase
        ctrl_d = (state_d != TC_IDLE);
    end

    assign ctrl = ctrl_q;

endmodule

// File: rtl/smu_trigger_ctrl.sv
// Maps registered smu triggers onto C patch-control channels and counts channel activations.
module smu_trigger_ctrl
    import smu_pkg::*;
#(
    parameter int M      = 6,
    parameter int C      = 4,
    parameter int HOLD_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [M-1:0]          trigger,
    input  logic                  CfgEn,
    input  logic [C*M-1:0]        CfgTrigMask,
    input  logic [C*HOLD_W-1:0]   CfgHold,
    input  logic [C-1:0]          CfgSticky,
    input  logic [C-1:0]          ctrl_clr,
    input  logic                  cnt_clr,
    output logic [C-1:0]          ctrl,
    output logic [CNT_W-1:0]      event_cnt,
    output logic                  cnt_ovf
);

    localparam int PCW = $clog2(C + 1);
    localparam int SW  = CNT_W + PCW;
    localparam logic [SW-1:0] CNT_MAX = {{PCW{1'b0}}, {CNT_W{1'b1}}};

    logic [M-1:0]     trig_q, trig_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             ovf_q,  ovf_d;
    logic [C-1:0]     hit_s;
    logic [C-1:0]     start_s;
    logic [PCW-1:0]   pop_s;
    logic [SW-1:0]    sum_s;

    // Trigger capture stage plus event counter state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trig_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            trig_q <= trig_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    // Per-channel hit from the registered trigger vector, gated by the global enable
    always_comb begin
        trig_d = trigger;
        hit_s  = '0;
        for (int c = 0; c < C; c++) begin
            hit_s[c] = CfgEn & (|(trig_q & CfgTrigMask[c*M +: M]));
        end
    end

    genvar g;
    generate
        for (g = 0; g < C; g++) begin : g_chan
            smu_trigger_ctrl_chan #(
                .HOLD_W (HOLD_W)
            ) u_chan (
                .clk    (clk),
                .rst    (rst),
                .hit    (hit_s[g]),
                .clr    (ctrl_clr[g]),
                .hold   (CfgHold[g*HOLD_W +: HOLD_W]),
                .sticky (CfgSticky[g]),
                .ctrl   (ctrl[g]),
                .start  (start_s[g])
            );
        end
    endgenerate

    // Saturating activation counter; clear beats a same-cycle increment
    always_comb begin
        pop_s = '0;
        for (int c = 0; c < C; c++) begin
            pop_s = pop_s + PCW'(start_s[c]);
        end
        sum_s = SW'(cnt_q) + SW'(pop_s);
        if (cnt_clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (sum_s > CNT_MAX) begin
            cnt_d = {CNT_W{1'b1}};
            ovf_d = 1'b1;
        end else begin
            cnt_d = sum_s[CNT_W-1:0];
            ovf_d = ovf_q;
        end
    end

    assign event_cnt = cnt_q;
    assign cnt_ovf   = ovf_q;

endmodule

// File: tb/tb_smu_trigger_ctrl.sv
// Self-checking bench for smu_trigger_ctrl: vector table plus hand sequences, scoreboard compare.
module tb_smu_trigger_ctrl;

    localparam int M      = 6;
    localparam int C      = 4;
    localparam int HOLD_W = 8;
    localparam int CNT_W  = 4;

    logic                clk;
    logic                rst;
    logic [M-1:0]        trigger;
    logic                cfg_en;
    logic [C*M-1:0]      cfg_mask;
    logic [C*HOLD_W-1:0] cfg_hold;
    logic [C-1:0]        cfg_sticky;
    logic [C-1:0]        ctrl_clr;
    logic                cnt_clr;
    logic [C-1:0]        ctrl;
    logic [CNT_W-1:0]    event_cnt;
    logic                cnt_ovf;

    int checks   = 0;
    int failures = 0;
    int step_id  = 0;

    typedef struct packed {
        logic [M-1:0] trig;
        logic [C-1:0] clr;
        logic         en;
        logic [C-1:0] ectrl;
        logic [3:0]   ecnt;
    } vec_t;

    typedef struct packed {
        logic [C-1:0]     ctrl;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    smu_trigger_ctrl #(
        .M      (M),
        .C      (C),
        .HOLD_W (HOLD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trigger     (trigger),
        .CfgEn       (cfg_en),
        .CfgTrigMask (cfg_mask),
        .CfgHold     (cfg_hold),
        .CfgSticky   (cfg_sticky),
        .ctrl_clr    (ctrl_clr),
        .cnt_clr     (cnt_clr),
        .ctrl        (ctrl),
        .event_cnt   (event_cnt),
        .cnt_ovf     (cnt_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    // Drive one cycle of stimulus at a negedge, push its expectation, compare at the next negedge
    task automatic step(input logic [M-1:0] trig, input logic [C-1:0] clr, input logic cclr,
                        input logic en, input logic [C-1:0] ectrl, input logic [CNT_W-1:0] ecnt,
                        input logic eovf);
        exp_t e;
        exp_t a;
        trigger  = trig;
        ctrl_clr = clr;
        cnt_clr  = cclr;
        cfg_en   = en;
        sb.push_back('{ectrl, ecnt, eovf});
        @(posedge clk);
        @(negedge clk);
        a = '{ctrl, event_cnt, cnt_ovf};
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL step%0d scoreboard empty, actual=%b required=entry", step_id, a);
        end else begin
            e = sb.pop_front();
            if (a !== e) begin
                failures++;
                $display("FAIL step%0d ctrl/cnt/ovf actual=%b/%0d/%b required=%b/%0d/%b",
                         step_id, a.ctrl, a.cnt, a.ovf, e.ctrl, e.cnt, e.ovf);
            end
        end
        step_id++;
    endtask

    task automatic check_reset_state(input int tag);
        checks++;
        if (ctrl !== 4'b0000 || event_cnt !== 4'd0 || cnt_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset%0d ctrl/cnt/ovf actual=%b/%0d/%b required=0000/0/0",
                     tag, ctrl, event_cnt, cnt_ovf);
        end
    endtask

    initial begin
        rst        = 1'b0;
        trigger    = '0;
        cfg_en     = 1'b1;
        ctrl_clr   = '0;
        cnt_clr    = 1'b0;
        cfg_mask   = {6'b001000, 6'b000100, 6'b000010, 6'b000001};
        cfg_hold   = {8'd0, 8'd0, 8'd2, 8'd3};
        cfg_sticky = 4'b0100;
        repeat (2) @(negedge clk);
        check_reset_state(0);
        rst = 1'b1;

        // trig, clr, en, expected ctrl, expected count (seen one edge after the row is driven)
        tbl.push_back('{6'b000001, 4'b0000, 1'b1, 4'b0000, 4'd0});
        tbl.push_back('{6'b000000, 4'b0000, 1'b1, 4'b0001, 4'd1});
        tbl.push_back('{6'b000000, 4'b0000, 1'b1, 4'b0001, 4'd1});
        tbl.push_back('{6'b000000, 4'b0000, 1'b1, 4'b0001, 4'd1});
        tbl.push_back('{6'b000000, 4'b0000, 1'b1, 4'b0001, 4'd1});
        tbl.push_back('{6'b000000, 4'b0000, 1'b1, 4'b0000, 4'd1});
        tbl.push_back('{6'b000010, 4'b0000, 1'b1, 4'b0000, 4'd1});
        tbl.push_back('{6'b000000, 4'b0000, 1'b1, 4'b0010, 4'd2});
        tbl.push_back('{6'b000010, 4'b0000, 1'b1, 4'b0010, 4'd2});
        tbl.push_back('{6'b000000, 4'b0000, 1'b1, 4'b0010, 4'd2});
        tbl.push_back('{6'b000000, 4'b0000, 1'b1, 4'b0010, 4'd2});
        tbl.push_back('{6'b000000, 4'b0000, 1'b1, 4'b0010, 4'd2});
        tbl.push_back('{6'b000000, 4'b0000, 1'b1, 4'b0000, 4'd2});
        tbl.push_back('{6'b000100, 4'b0000, 1'b1, 4'b0000, 4'd2});
        tbl.push_back('{6'b000000, 4'b0000, 1'b1, 4'b0100, 4'd3});
        tbl.push_back('{6'b000100, 4'b0000, 1'b1, 4'b0100, 4'd3});
        tbl.push_back('{6'b000000, 4'b0100, 1'b1, 4'b0000, 4'd3});
        tbl.push_back('{6'b000100, 4'b0000, 1'b1, 4'b0000, 4'd3});
        tbl.push_back('{6'b000000, 4'b0100, 1'b1, 4'b0000, 4'd3});
        tbl.push_back('{6'b000000, 4'b0000, 1'b1, 4'b0000, 4'd3});
        tbl.push_back('{6'b000001, 4'b0000, 1'b1, 4'b0000, 4'd3});
        tbl.push_back('{6'b000000, 4'b0000, 1'b1, 4'b0001, 4'd4});
        tbl.push_back('{6'b000000, 4'b0001, 1'b1, 4'b0000, 4'd4});
        tbl.push_back('{6'b000000, 4'b0000, 1'b1, 4'b0000, 4'd4});
        tbl.push_back('{6'b111111, 4'b0000, 1'b0, 4'b0000, 4'd4});
        tbl.push_back('{6'b000000, 4'b0000, 1'b0, 4'b0000, 4'd4});
        tbl.push_back('{6'b111111, 4'b0000, 1'b0, 4'b0000, 4'd4});
        tbl.push_back('{6'b000000, 4'b0000, 1'b0, 4'b0000, 4'd4});
        tbl.push_back('{6'b000000, 4'b0000, 1'b1, 4'b0000, 4'd4});
        tbl.push_back('{6'b001001, 4'b0000, 1'b1, 4'b0000, 4'd4});
        tbl.push_back('{6'b000000, 4'b0000, 1'b1, 4'b1001, 4'd6});
        tbl.push_back('{6'b000000, 4'b0000, 1'b0, 4'b0001, 4'd6});
        tbl.push_back('{6'b000000, 4'b0000, 1'b0, 4'b0001, 4'd6});
        tbl.push_back('{6'b000000, 4'b0000, 1'b1, 4'b0001, 4'd6});
        tbl.push_back('{6'b000000, 4'b0000, 1'b1, 4'b0000, 4'd6});

        foreach (tbl[i]) begin
            step(tbl[i].trig, tbl[i].clr, 1'b0, tbl[i].en, tbl[i].ectrl, tbl[i].ecnt, 1'b0);
        end

        // Sticky channel holds for 20 cycles; flipping CfgSticky meanwhile has no effect
        step(6'b000000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'd0, 1'b0);
        step(6'b000100, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'd0, 1'b0);
        step(6'b000000, 4'b0000, 1'b0, 1'b1, 4'b0100, 4'd1, 1'b0);
        cfg_sticky = 4'b0000;
        for (int i = 0; i < 19; i++) begin
            step((i % 3 == 0) ? 6'b000100 : 6'b000000, 4'b0000, 1'b0, 1'b1, 4'b0100, 4'd1, 1'b0);
        end
        step(6'b000000, 4'b0100, 1'b0, 1'b1, 4'b0000, 4'd1, 1'b0);
        step(6'b000100, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'd1, 1'b0);
        step(6'b000000, 4'b0000, 1'b0, 1'b1, 4'b0100, 4'd2, 1'b0);
        step(6'b000000, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'd2, 1'b0);

        // All channels on trigger[5] with zero hold: +4 per pulse, saturating at 15
        cfg_mask   = {4{6'b100000}};
        cfg_hold   = '0;
        cfg_sticky = 4'b0000;
        step(6'b000000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'd0, 1'b0);
        for (int p = 1; p <= 3; p++) begin
            step(6'b100000, 4'b0000, 1'b0, 1'b1, 4'b0000, CNT_W'(4 * (p - 1)), 1'b0);
            step(6'b000000, 4'b0000, 1'b0, 1'b1, 4'b1111, CNT_W'(4 * p), 1'b0);
        end
        step(6'b100000, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'd12, 1'b0);
        step(6'b000000, 4'b0000, 1'b0, 1'b1, 4'b1111, 4'd15, 1'b1);
        step(6'b100000, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'd15, 1'b1);
        step(6'b000000, 4'b0000, 1'b0, 1'b1, 4'b1111, 4'd15, 1'b1);
        step(6'b100000, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'd15, 1'b1);
        step(6'b000000, 4'b0000, 1'b1, 1'b1, 4'b1111, 4'd0, 1'b0);
        step(6'b000000, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'd0, 1'b0);

        // Asynchronous reset while one channel is ACTIVE and another STICKY
        cfg_mask   = {6'b001000, 6'b000100, 6'b000010, 6'b000001};
        cfg_hold   = {8'd0, 8'd0, 8'd0, 8'd200};
        cfg_sticky = 4'b0100;
        step(6'b000101, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'd0, 1'b0);
        step(6'b000000, 4'b0000, 1'b0, 1'b1, 4'b0101, 4'd2, 1'b0);
        step(6'b000000, 4'b0000, 1'b0, 1'b1, 4'b0101, 4'd2, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_state(1);
        @(negedge clk);
        check_reset_state(2);
        rst = 1'b1;
        step(6'b000001, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'd0, 1'b0);
        step(6'b000000, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'd1, 1'b0);
        step(6'b000000, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'd1, 1'b0);
        step(6'b000000, 4'b0001, 1'b0, 1'b1, 4'b0000, 4'd1, 1'b0);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain leftover actual=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
